// File: rtl/npc_predict_unit.sv
// npc_predict_unit: fetch-stage next-PC generator with optional direct-mapped BTB.
// Owns the PC register. Taken predictions redirect fetch after the delay slot.
// Branches and jumps resolve in the E stage and drive the mispredict flush.
// Build option: define NPC_BTB_EN to build the BTB, its direction counters and
// the pending-redirect logic. Without it, every fetch is predicted not-taken.
module npc_predict_unit #(
  parameter int          BTB_DEPTH = 16,
  parameter int          CNT_BITS  = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  output logic [31:0] pc_f_o,
  output logic        pred_taken_f_o,
  output logic [31:0] pred_target_f_o,
  input  logic        res_valid_i,
  input  logic [31:0] res_pc_i,
  input  logic        res_is_branch_i,
  input  logic        res_is_jump_i,
  input  logic        res_taken_i,
  input  logic [31:0] res_target_i,
  input  logic        res_pred_taken_i,
  input  logic [31:0] res_pred_target_i,
  output logic        flush_f_o
);

  localparam int IDX   = $clog2(BTB_DEPTH);
  localparam int TAG_W = 30 - IDX;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic        mispredict;

  assign pc_plus4    = pc_q + 32'd4;
  assign redirect_pc = res_taken_i ? res_target_i : (res_pc_i + 32'd8);
  assign mispredict  = res_valid_i &
                       ((res_taken_i != res_pred_taken_i) |
                        (res_taken_i & (res_target_i != res_pred_target_i)));

  assign flush_f_o = mispredict;
  assign pc_f_o    = pc_q;

`ifdef NPC_BTB_EN
  localparam logic [CNT_BITS-1:0] CNT_RST   = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_ALLOC = CNT_BITS'(1 << (CNT_BITS - 1));
  localparam logic [CNT_BITS-1:0] CNT_MAX   = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);

  logic [BTB_DEPTH-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
  logic [31:0]          tgt_q [BTB_DEPTH];
  logic [CNT_BITS-1:0]  cnt_q [BTB_DEPTH];

  logic              pend_valid_q, pend_valid_d;
  logic [31:0]       pend_target_q, pend_target_d;

  logic [IDX-1:0]    f_idx, r_idx;
  logic [TAG_W-1:0]  f_tag, r_tag;
  logic              f_hit, r_hit;

  logic              btb_we;
  logic [CNT_BITS-1:0] wr_cnt;
  logic [31:0]       wr_tgt;

  assign f_idx = pc_q[2+IDX-1:2];
  assign f_tag = pc_q[31:2+IDX];
  assign r_idx = res_pc_i[2+IDX-1:2];
  assign r_tag = res_pc_i[31:2+IDX];

  assign f_hit = valid_q[f_idx] & (tag_q[f_idx] == f_tag);
  assign r_hit = valid_q[r_idx] & (tag_q[r_idx] == r_tag);

  assign pred_taken_f_o  = f_hit & cnt_q[f_idx][CNT_BITS-1];
  assign pred_target_f_o = pred_taken_f_o ? tgt_q[f_idx] : 32'd0;

  // Next PC: mispredict beats stall; a pending redirect lands after the delay slot.
  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (mispredict) begin
      pc_d         = redirect_pc;
      pend_valid_d = 1'b0;
    end else if (!stall_i) begin
      if (pend_valid_q) begin
        pc_d         = pend_target_q;
        pend_valid_d = 1'b0;
      end else begin
        pc_d = pc_plus4;
        if (pred_taken_f_o) begin
          pend_valid_d  = 1'b1;
          pend_target_d = pred_target_f_o;
        end
      end
    end
  end

  // BTB write decision from the E-stage resolution; jr (no kind bit) never writes.
  always_comb begin
    btb_we = 1'b0;
    wr_cnt = cnt_q[r_idx];
    wr_tgt = res_target_i;
    if (res_valid_i && res_is_branch_i) begin
      if (r_hit) begin
        btb_we = 1'b1;
        wr_tgt = tgt_q[r_idx];
        if (res_taken_i) begin
          if (cnt_q[r_idx] != CNT_MAX) wr_cnt = cnt_q[r_idx] + CNT_ONE;
        end else begin
          if (cnt_q[r_idx] != CNT_ZERO) wr_cnt = cnt_q[r_idx] - CNT_ONE;
        end
      end else if (res_taken_i) begin
        btb_we = 1'b1;
        wr_cnt = CNT_ALLOC;
      end
    end else if (res_valid_i && res_is_jump_i) begin
      btb_we = 1'b1;
      wr_cnt = CNT_MAX;
    end
  end

  // BTB storage; writes land at the edge so same-cycle lookups see old content.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= CNT_RST;
      end
    end else if (btb_we) begin
      valid_q[r_idx] <= 1'b1;
      tag_q[r_idx]   <= r_tag;
      tgt_q[r_idx]   <= wr_tgt;
      cnt_q[r_idx]   <= wr_cnt;
    end
  end

  // Pending delay-slot redirect register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end
`else
  logic unused_res_kind;
  assign unused_res_kind = res_is_branch_i ^ res_is_jump_i;

  assign pred_taken_f_o  = 1'b0;
  assign pred_target_f_o = 32'd0;

  // Next PC without prediction: mispredict redirect, stall hold, else sequential.
  always_comb begin
    pc_d = pc_q;
    if (mispredict) begin
      pc_d = redirect_pc;
    end else if (!stall_i) begin
      pc_d = pc_plus4;
    end
  end
`endif

  // Fetch PC register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_npc_predict_unit.sv
// Bench for npc_predict_unit: directed scenarios plus randomized resolution traffic,
// checked every cycle against a behavioural next-PC / BTB model.
module tb_npc_predict_unit;
  localparam int          DEPTH = 16;
  localparam int          CB    = 2;
  localparam logic [31:0] RPC   = 32'h0000_3000;
  localparam int          IDX   = $clog2(DEPTH);
  localparam int          HALF  = 1 << (CB - 1);
  localparam int          CMAX  = (1 << CB) - 1;
`ifdef NPC_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        res_valid = 1'b0;
  logic [31:0] res_pc = '0;
  logic        res_is_branch = 1'b0;
  logic        res_is_jump = 1'b0;
  logic        res_taken = 1'b0;
  logic [31:0] res_target = '0;
  logic        res_pred_taken = 1'b0;
  logic [31:0] res_pred_target = '0;
  logic        flush_f;

  int checks = 0;
  int errors = 0;

  npc_predict_unit #(.BTB_DEPTH(DEPTH), .CNT_BITS(CB), .RESET_PC(RPC)) dut (
    .clk_i(clk), .reset_i(reset_i), .stall_i(stall),
    .pc_f_o(pc_f), .pred_taken_f_o(pred_taken_f), .pred_target_f_o(pred_target_f),
    .res_valid_i(res_valid), .res_pc_i(res_pc), .res_is_branch_i(res_is_branch),
    .res_is_jump_i(res_is_jump), .res_taken_i(res_taken), .res_target_i(res_target),
    .res_pred_taken_i(res_pred_taken), .res_pred_target_i(res_pred_target),
    .flush_f_o(flush_f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pend_tgt;
  bit          m_v   [DEPTH];
  logic [31:0] m_epc [DEPTH];
  logic [31:0] m_tgt [DEPTH];
  int          m_cnt [DEPTH];

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit same_tag(input logic [31:0] a, input logic [31:0] b);
    return (a >> (2 + IDX)) == (b >> (2 + IDX));
  endfunction

  function automatic void m_lookup(input logic [31:0] a, output bit t, output logic [31:0] tg);
    int s = slot(a);
    t  = 1'b0;
    tg = 32'd0;
    if (BTB && m_v[s] && same_tag(m_epc[s], a) && m_cnt[s] >= HALF) begin
      t  = 1'b1;
      tg = m_tgt[s];
    end
  endfunction

  function automatic bit m_flush();
    if (!res_valid) return 1'b0;
    if (res_taken != res_pred_taken) return 1'b1;
    return res_taken && (res_target != res_pred_target);
  endfunction

  function automatic void m_reset();
    m_pc   = RPC;
    m_pend = 1'b0;
    m_pend_tgt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 1'b0; m_epc[i] = '0; m_tgt[i] = '0; m_cnt[i] = HALF - 1;
    end
  endfunction

  function automatic void m_step();
    bit pt; logic [31:0] ptg; int s; bit hit;
    m_lookup(m_pc, pt, ptg);
    s   = slot(res_pc);
    hit = m_v[s] && same_tag(m_epc[s], res_pc);
    if (m_flush()) begin
      m_pc   = res_taken ? res_target : res_pc + 32'd8;
      m_pend = 1'b0;
    end else if (!stall) begin
      if (m_pend) begin
        m_pc   = m_pend_tgt;
        m_pend = 1'b0;
      end else begin
        m_pc = m_pc + 32'd4;
        if (pt) begin m_pend = 1'b1; m_pend_tgt = ptg; end
      end
    end
    if (BTB && res_valid && res_is_branch) begin
      if (hit) begin
        m_cnt[s] = res_taken ? ((m_cnt[s] < CMAX) ? m_cnt[s] + 1 : CMAX)
                             : ((m_cnt[s] > 0) ? m_cnt[s] - 1 : 0);
      end else if (res_taken) begin
        m_v[s] = 1'b1; m_epc[s] = res_pc; m_tgt[s] = res_target; m_cnt[s] = HALF;
      end
    end else if (BTB && res_valid && res_is_jump) begin
      m_v[s] = 1'b1; m_epc[s] = res_pc; m_tgt[s] = res_target; m_cnt[s] = CMAX;
    end
  endfunction

  // model advances on the same edges as the DUT
  always @(posedge clk or posedge reset_i) begin
    if (reset_i) m_reset();
    else m_step();
  end

  // compare process: every non-reset cycle, away from the active edge
  always @(negedge clk) begin
    bit et; logic [31:0] etg;
    if (!reset_i) begin
      m_lookup(m_pc, et, etg);
      chk("pc_f", pc_f, m_pc);
      chk("pred_taken_f", {31'd0, pred_taken_f}, {31'd0, et});
      chk("pred_target_f", pred_target_f, etg);
      chk("flush_f", {31'd0, flush_f}, {31'd0, m_flush()});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_res();
    res_valid = 1'b0; res_pc = '0; res_is_branch = 1'b0; res_is_jump = 1'b0;
    res_taken = 1'b0; res_target = '0; res_pred_taken = 1'b0; res_pred_target = '0;
  endtask

  task automatic set_res(input logic [31:0] pc, input bit br, input bit jp, input bit tk,
                         input logic [31:0] tg, input bit ptk, input logic [31:0] ptg);
    res_valid = 1'b1; res_pc = pc; res_is_branch = br; res_is_jump = jp;
    res_taken = tk; res_target = tg; res_pred_taken = ptk; res_pred_target = ptg;
  endtask

  // redirect fetch through a jr-style mispredict
  task automatic jump_to(input logic [31:0] tg);
    set_res(32'h0000_4000, 1'b0, 1'b0, 1'b1, tg, 1'b0, 32'd0);
    tick();
    clr_res();
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'h0000_3000 + 32'(4 * $urandom_range(0, 47));
  endfunction

  initial begin
    bit mt; logic [31:0] mtg; int r;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;

    // sequential fetch from reset
    chk("reset_pc", pc_f, 32'h3000);
    chk("reset_flush", {31'd0, flush_f}, 32'd0);
    chk("reset_pred", {31'd0, pred_taken_f}, 32'd0);
    chk("reset_ptgt", pred_target_f, 32'd0);
    tick(); chk("seq_3004", pc_f, 32'h3004);
    tick(); chk("seq_3008", pc_f, 32'h3008);
    tick(); chk("seq_300c", pc_f, 32'h300C);
    tick(); chk("seq_3010", pc_f, 32'h3010);

    // first taken beq at 3010 -> 3040, unpredicted
    set_res(32'h3010, 1'b1, 1'b0, 1'b1, 32'h3040, 1'b0, 32'd0);
    #1 chk("beq_first_flush", {31'd0, flush_f}, 32'd1);
    tick(); clr_res();
    chk("beq_first_redirect", pc_f, 32'h3040);

    // refetch the same beq
    jump_to(32'h3010);
    chk("refetch_pc", pc_f, 32'h3010);
    chk("refetch_pred", {31'd0, pred_taken_f}, BTB ? 32'd1 : 32'd0);
    chk("refetch_ptgt", pred_target_f, BTB ? 32'h3040 : 32'd0);
    tick(); chk("delay_slot_pc", pc_f, 32'h3014);
    tick(); chk("taken_target_pc", pc_f, BTB ? 32'h3040 : 32'h3018);
    set_res(32'h3010, 1'b1, 1'b0, 1'b1, 32'h3040, BTB, BTB ? 32'h3040 : 32'd0);
    #1 chk("beq_pred_flush", {31'd0, flush_f}, BTB ? 32'd0 : 32'd1);
    tick(); clr_res();
    chk("after_beq_pred", pc_f, BTB ? 32'h3044 : 32'h3040);

    // predicted-taken branch resolves not-taken
    set_res(32'h3010, 1'b1, 1'b0, 1'b0, 32'h3040, 1'b1, 32'h3040);
    #1 chk("nt_flush", {31'd0, flush_f}, 32'd1);
    tick(); clr_res();
    chk("nt_redirect", pc_f, 32'h3018);

    // stall holds, mispredict during stall wins
    stall = 1'b1;
    repeat (3) begin tick(); chk("stall_hold", pc_f, 32'h3018); end
    set_res(32'h3020, 1'b0, 1'b0, 1'b1, 32'h3200, 1'b0, 32'd0);
    tick(); clr_res();
    chk("stall_redirect", pc_f, 32'h3200);
    stall = 1'b0;
    tick(); chk("post_stall_seq", pc_f, 32'h3204);

`ifdef NPC_BTB_EN
    // pending redirect survives a stall
    jump_to(32'h3010);
    tick(); chk("pend_slot", pc_f, 32'h3014);
    stall = 1'b1;
    repeat (3) begin tick(); chk("pend_stall_hold", pc_f, 32'h3014); end
    stall = 1'b0;
    tick(); chk("pend_release", pc_f, 32'h3040);
    // mispredict during stall clears the pending redirect
    jump_to(32'h3010);
    tick(); chk("pend_slot2", pc_f, 32'h3014);
    stall = 1'b1;
    set_res(32'h3020, 1'b0, 1'b0, 1'b1, 32'h3300, 1'b0, 32'd0);
    tick(); clr_res(); stall = 1'b0;
    chk("pend_kill_redirect", pc_f, 32'h3300);
    tick(); chk("pend_cleared", pc_f, 32'h3304);
`endif

    // jr to 3100
    set_res(32'h3050, 1'b0, 1'b0, 1'b1, 32'h3100, 1'b0, 32'd0);
    #1 chk("jr_flush", {31'd0, flush_f}, 32'd1);
    tick(); clr_res();
    chk("jr_redirect", pc_f, 32'h3100);

    // 32-bit wrap of PC+4 and PC+8
    jump_to(32'hFFFF_FFFC);
    chk("wrap_top", pc_f, 32'hFFFF_FFFC);
    tick(); chk("wrap_plus4", pc_f, 32'h0);
    set_res(32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0, 32'h1234, 1'b1, 32'h1234);
    tick(); clr_res();
    chk("wrap_plus8", pc_f, 32'h0);

    // asynchronous reset mid-operation
    tick(); tick();
    reset_i = 1'b1;
    #1 chk("async_reset_pc", pc_f, 32'h3000);
    tick(); reset_i = 1'b0;
    chk("post_reset_pc", pc_f, 32'h3000);
    tick(); chk("post_reset_seq", pc_f, 32'h3004);
    jump_to(32'h3010);
    chk("btb_cleared", {31'd0, pred_taken_f}, 32'd0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      clr_res();
      stall = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 499) == 0) begin
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        continue;
      end
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 3);
        res_valid     = 1'b1;
        res_pc        = rnd_addr();
        res_is_branch = (r < 2);
        res_is_jump   = (r == 2);
        res_taken     = (r >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
        res_target    = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFF0 : rnd_addr();
        m_lookup(res_pc, mt, mtg);
        if ($urandom_range(0, 1) == 0) begin
          res_pred_taken  = mt;
          res_pred_target = (mt && $urandom_range(0, 3) != 0) ? res_target : mtg;
        end else begin
          res_pred_taken  = 1'($urandom_range(0, 1));
          res_pred_target = res_pred_taken ? rnd_addr() : 32'd0;
        end
      end
      tick();
    end
    clr_res();
    stall = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/npc_predict_unit.md
# npc_predict_unit

Fetch-stage next-PC generator for the delay-slot MIPS pipeline, successor to the combinational decode-stage next-PC logic. Owns the PC register and a direct-mapped branch target buffer (BTB) with saturating direction counters, so branches and jumps can be redirected at fetch time. Branch resolution moves to the E stage. Sits between the hazard unit (stall), the instruction memory (`pc_f`) and the E-stage resolution bus.

## Interface
- `BTB_DEPTH`, 16, BTB entries; power of two, ≥2; `IDX = log2(BTB_DEPTH)`.
- `CNT_BITS`, 2, direction counter width; ≥1.
- `RESET_PC`, 32'h0000_3000, PC value after reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `stall`  in  1  hazard unit hold of F and D.
- `pc_f`  out  32  current fetch address (registered).
- `pred_taken_f`  out  1  BTB hit with counter MSB = 1 for `pc_f`; pipelined with the instruction.
- `pred_target_f`  out  32  predicted target for `pc_f`; 0 when not predicted.
- `res_valid`  in  1  E-stage control-flow instruction resolved this cycle.
- `res_pc`  in  32  PC of the resolving instruction.
- `res_is_branch`  in  1  conditional branch (beq, bne, ...).
- `res_is_jump`  in  1  j or jal; jr carries 0 on both kind bits.
- `res_taken`, `res_target`  in  1, 32  actual outcome and target.
- `res_pred_taken`, `res_pred_target`  in  1, 32  prediction carried down the pipe.
- `flush_f`  out  1  mispredict; kill the instruction being fetched this cycle.

## Operation
- BTB entry: valid, tag `pc[31:2+IDX]`, target[31:0], counter. Index `pc[2+IDX-1:2]`.
- Lookup: combinational on `pc_f`. Hit requires valid and tag match.
- Delay slot: a predicted-taken fetch at X does not redirect the next fetch. It loads `pend_valid`=1 and `pend_target`=T. The next PC is X+4; the PC after that is T.
- Mispredict (`flush_f`) = `res_valid` & (`res_taken` != `res_pred_taken` | (`res_taken` & `res_target` != `res_pred_target`)).
- Redirect PC = `res_taken` ? `res_target` : `res_pc`+8.
- Next-PC priority, highest first:
  1. reset;
  2. mispredict: PC <= redirect, `pend_valid` <= 0, applies even when `stall`=1;
  3. `stall`: PC and pending state hold;
  4. `pend_valid`: PC <= `pend_target`, then `pend_valid` <= 0;
  5. otherwise PC <= PC+4. Set pending if `pred_taken_f`.
- Counter update, on `res_valid` & `res_is_branch`:
  - hit: saturating increment if taken, decrement if not;
  - miss and taken: allocate (overwrite) with counter `10..0`, weakly taken, and target;
  - miss and not taken: no write.
- Jump update, on `res_valid` & `res_is_jump`: allocate or refresh with counter all-ones and target.
- jr: never written to the BTB. Always predicted not-taken, so it always mispredicts.
- Arithmetic: modulo 2^32. PC+4 and PC+8 wrap at 32'hFFFF_FFFC without a flag.

## Timing
- Reset values: `pc_f`=`RESET_PC`, `pend_valid`=0, all BTB valid=0, counters `01..1`. Outputs: `pred_taken_f`=0, `pred_target_f`=0, `flush_f`=0.
- `flush_f` is combinational from the `res_*` inputs, same cycle. The PC takes the redirect at the next edge: one-bubble penalty.
- BTB writes land at the clock edge. A lookup in the same cycle and index returns the pre-write content.
- Prediction latency: 0 cycles (same cycle as `pc_f`). Taken-target fetch occurs 2 cycles after the branch fetch, with no bubble.
- Reset mid-operation: pending redirect discarded; the next fetch is `RESET_PC`.

## Configuration
- `NPC_BTB_EN` defined: BTB and counters built as above.
- Not defined: no BTB storage. `pred_taken_f`=0 and `pred_target_f`=0 always, and pending logic is removed. Every taken branch or jump mispredicts, redirects with one bubble, and behaves otherwise identically.

## Test plan
- Reset, no stall, 4 cycles -> `pc_f` = 3000, 3004, 3008, 300C; `flush_f`=0.
- First taken beq at 3010 → 3040, resolving with pred 0 -> `flush_f`=1 that cycle; the next `pc_f`=3040; the entry is allocated with counter 10.
- Same beq refetched -> `pred_taken_f`=1 at 3010; `pc_f` sequence 3010, 3014, 3040. Resolution with pred 1 / 3040 -> `flush_f`=0; counter 11.
- Predicted-taken branch resolves not-taken, `res_pc`=3010 -> `flush_f`=1; next `pc_f`=3018; counter decrements.
- `stall`=1 for 3 cycles while `pend_valid`=1 -> `pc_f` and pending hold. Mispredict during stall -> redirect wins and pending is cleared.
- jr resolving to 3100 with `res_pred_taken`=0 -> `flush_f`=1; `pc_f`=3100; no BTB write. With `NPC_BTB_EN` undefined, repeat scenario 3 -> `flush_f`=1 every iteration.
